uart_rx_param: RTL and testbench

//  Parametrised UART receive core, successor to the fixed 8-bit receiver. Oversamples rx_i on acq_i

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_param.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and FIFO entry layout {frame_err, parity_err, data}.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_STOP2,
        RX_BREAK
    } rx_state_e;

    localparam int TAG_W = 2;

    function automatic int entry_w(input int data_w);
        return data_w + TAG_W;
    endfunction

    function automatic int perr_pos(input int data_w);
        return data_w;
    endfunction

    function automatic int ferr_pos(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; head reads as zero while empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [LW-1:0]    cnt;
    logic             do_wr, do_rd;

    // A write into a full FIFO still lands when the head is popped in the same cycle.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == LW'(DEPTH));
    assign level = cnt;
    assign rdata = empty ? '0 : mem[rp];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with error-tagged FIFO.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around mid-bit.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acq_i,
    input  logic                          rx_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          msb_first_i,
    input  logic                          two_stop_i,
    input  logic                          rd_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o,
    input  logic                          clr_ovr_i
);
    localparam int ENTRY_W = entry_w(DATA_W);
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_W);
    localparam int HALF    = OVERSAMPLE / 2;

    rx_state_e          state;
    logic [1:0]         sync;
    logic               rx_s, rx_d;
    logic [TW-1:0]      tick;
    logic [BW-1:0]      bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               perr, ferr;
    logic               cfg_par, cfg_odd, cfg_msb, cfg_two;
    logic               wr;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic               bit_val, sample, stop_fe, full;

    assign rx_s = sync[1];

`ifdef UART_RX_MAJORITY_EN
    // Decision waits for the third vote, one tick after the single-sample point.
    localparam int DEC_TICK = HALF;
    logic [1:0] vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote <= 2'b11;
        end else if (acq_i) begin
            if (tick == TW'(HALF - 2)) vote[0] <= rx_s;
            if (tick == TW'(HALF - 1)) vote[1] <= rx_s;
        end
    end

    assign bit_val = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
`else
    localparam int DEC_TICK = HALF - 1;
    assign bit_val = rx_s;
`endif

    assign sample  = acq_i && (tick == TW'(DEC_TICK));
    assign stop_fe = !bit_val || (state == RX_STOP2 && ferr);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            rx_d    <= 1'b1;
            state   <= RX_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            cfg_par <= 1'b0;
            cfg_odd <= 1'b0;
            cfg_msb <= 1'b0;
            cfg_two <= 1'b0;
            wr      <= 1'b0;
            wdata   <= '0;
        end else begin
            sync <= {sync[0], rx_i};
            rx_d <= rx_s;
            wr   <= 1'b0;
            if (acq_i) tick <= (tick == TW'(OVERSAMPLE - 1)) ? '0 : tick + 1'b1;

            case (state)
                RX_IDLE: if (rx_d && !rx_s) begin
                    state <= RX_START;
                    tick  <= '0;
                end
                RX_START: if (sample) begin
                    if (bit_val) begin
                        state <= RX_IDLE;
                    end else begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                        cfg_par <= parity_en_i;
                        cfg_odd <= parity_odd_i;
                        cfg_msb <= msb_first_i;
                        cfg_two <= two_stop_i;
                    end
                end
                RX_DATA: if (sample) begin
                    shreg <= cfg_msb ? {shreg[DATA_W-2:0], bit_val}
                                     : {bit_val, shreg[DATA_W-1:1]};
                    if (bit_cnt == BW'(DATA_W - 1)) state <= cfg_par ? RX_PARITY : RX_STOP;
                    else                            bit_cnt <= bit_cnt + 1'b1;
                end
                RX_PARITY: if (sample) begin
                    perr  <= bit_val ^ (^shreg) ^ cfg_odd;
                    state <= RX_STOP;
                end
                RX_STOP, RX_STOP2: if (sample) begin
                    if (state == RX_STOP && cfg_two) begin
                        ferr  <= !bit_val;
                        state <= RX_STOP2;
                    end else begin
                        // A low final stop is a break: hold off until the line returns high.
                        wr    <= 1'b1;
                        wdata <= {stop_fe, perr, shreg};
                        ferr  <= stop_fe;
                        state <= bit_val ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: if (rx_s) state <= RX_IDLE;
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       overrun_o <= 1'b0;
        else if (wr && full && !rd_i)  overrun_o <= 1'b1;
        else if (clr_ovr_i)            overrun_o <= 1'b0;
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .wdata (wdata),
        .rd    (rd_i),
        .rdata (rdata),
        .empty (empty_o),
        .full  (full),
        .level (level_o)
    );

    assign full_o       = full;
    assign data_o       = rdata[DATA_W-1:0];
    assign parity_err_o = rdata[perr_pos(DATA_W)];
    assign frame_err_o  = rdata[ferr_pos(DATA_W)];

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed-vector bench for uart_rx_param with a queue scoreboard and a draining monitor.
module tb_uart_rx_param;
    localparam int DATA_W  = 8;
    localparam int OS      = 16;
    localparam int DEPTH   = 4;
    localparam int ACQ_DIV = 4;
    localparam int BIT_CLK = OS * ACQ_DIV;

    logic        clk = 1'b0;
    logic        rst, acq_i, rx_i, parity_en_i, parity_odd_i, msb_first_i, two_stop_i;
    logic        rd_i, clr_ovr_i;
    logic [7:0]  data_o;
    logic        parity_err_o, frame_err_o, empty_o, full_o, overrun_o;
    logic [2:0]  level_o;

    int checks = 0;
    int failures = 0;
    bit auto_rd = 0;
    logic [9:0] sb[$];

    uart_rx_param #(.DATA_W(DATA_W), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .acq_i(acq_i), .rx_i(rx_i),
        .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
        .msb_first_i(msb_first_i), .two_stop_i(two_stop_i), .rd_i(rd_i),
        .data_o(data_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .empty_o(empty_o), .full_o(full_o), .level_o(level_o),
        .overrun_o(overrun_o), .clr_ovr_i(clr_ovr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int c = 0;
        acq_i = 1'b0;
        forever begin
            @(negedge clk);
            c = (c + 1) % ACQ_DIV;
            acq_i = (c == 0);
        end
    end

    // Monitor: pops and compares whenever a word is presented and draining is enabled.
    initial begin
        logic [9:0] exp;
        rd_i = 1'b0;
        forever begin
            @(negedge clk);
            rd_i = 1'b0;
            if (auto_rd && !empty_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {22'd0, frame_err_o, parity_err_o, data_o}, 32'h3ff);
                end else begin
                    exp = sb.pop_front();
                    chk("head_word", {22'd0, frame_err_o, parity_err_o, data_o}, {22'd0, exp});
                end
                rd_i = 1'b1;
            end
        end
    end

    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx_i = f[i];
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic idle(input int nbits);
        rx_i = 1'b1;
        repeat (BIT_CLK * nbits) @(negedge clk);
    endtask

    task automatic drain();
        bit done = 0;
        @(posedge clk); #1;
        auto_rd = 1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (empty_o) done = 1;
        end
        auto_rd = 0;
        chk("drain_timeout", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rx_i = 1'b1; clr_ovr_i = 1'b0;
        parity_en_i = 0; parity_odd_i = 0; msb_first_i = 0; two_stop_i = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_perr", {31'd0, parity_err_o}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        chk("rst_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        chk("rst_level", {29'd0, level_o}, 32'd0);
        chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
        idle(2);

        // 8N1 LSB first 0xA5
        sb.push_back({2'b00, 8'hA5});
        send_bits({6'd0, 1'b1, 8'hA5, 1'b0}, 10);
        idle(1);
        chk("a5_level", {29'd0, level_o}, 32'd1);
        chk("a5_empty", {31'd0, empty_o}, 32'd0);
        drain();

        // 8E1 0x03 with wrong parity bit 1
        parity_en_i = 1;
        sb.push_back({2'b01, 8'h03});
        send_bits({5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        idle(1);
        drain();

        // MSB first, odd parity, 0x1E with correct parity bit 1
        parity_odd_i = 1; msb_first_i = 1;
        sb.push_back({2'b00, 8'h1E});
        send_bits({5'd0, 1'b1, 1'b1, 8'h78, 1'b0}, 11);
        idle(1);
        drain();
        parity_en_i = 0; parity_odd_i = 0; msb_first_i = 0;

        // Start glitch of OS/4 ticks
        rx_i = 1'b0;
        repeat (OS / 4 * ACQ_DIV) @(negedge clk);
        idle(3);
        chk("glitch_empty", {31'd0, empty_o}, 32'd1);
        chk("glitch_level", {29'd0, level_o}, 32'd0);

        // Two stop bits, second one low
        two_stop_i = 1;
        sb.push_back({2'b10, 8'h3C});
        send_bits({5'd0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        idle(2);
        drain();
        two_stop_i = 0;

        // Break after 0x55: stop held low three bit times
        sb.push_back({2'b10, 8'h55});
        send_bits({7'd0, 8'h55, 1'b0}, 9);
        rx_i = 1'b0;
        repeat (3 * BIT_CLK) @(negedge clk);
        idle(2);
        chk("brk_level", {29'd0, level_o}, 32'd1);
        drain();

        // Overflow: DEPTH+1 words with no reads
        for (int w = 0; w <= DEPTH; w++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(w);
            if (w < DEPTH) sb.push_back({2'b00, d});
            send_bits({6'd0, 1'b1, d, 1'b0}, 10);
        end
        idle(1);
        chk("ovf_full", {31'd0, full_o}, 32'd1);
        chk("ovf_level", {29'd0, level_o}, DEPTH);
        chk("ovf_overrun", {31'd0, overrun_o}, 32'd1);
        chk("ovf_head", {24'd0, data_o}, 32'h10);
        drain();
        chk("ovf_full_after", {31'd0, full_o}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun_o}, 32'd1);
        clr_ovr_i = 1'b1;
        @(negedge clk);
        clr_ovr_i = 1'b0;
        @(negedge clk);
        chk("ovr_clear", {31'd0, overrun_o}, 32'd0);

        // Reset mid-DATA of 0x7E, then 0x81
        send_bits({7'd0, 8'h7E, 1'b0}, 4);
        rst = 1'b1; rx_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_empty", {31'd0, empty_o}, 32'd1);
        chk("mid_rst_level", {29'd0, level_o}, 32'd0);
        chk("mid_rst_flags", {29'd0, overrun_o, parity_err_o, frame_err_o}, 32'd0);
        idle(2);
        sb.push_back({2'b00, 8'h81});
        send_bits({6'd0, 1'b1, 8'h81, 1'b0}, 10);
        idle(1);
        chk("r81_level", {29'd0, level_o}, 32'd1);
        drain();

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
